// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing stage: phase encodings and default sizing.
package led_pkg;

    localparam int unsigned DEF_PWM_BITS   = 8;
    localparam int unsigned DEF_HOLD_STEPS = 16;
    localparam int unsigned HOLD_W         = 16;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_UP      = 3'd1,
        PH_HOLD_HI = 3'd2,
        PH_DOWN    = 3'd3,
        PH_HOLD_LO = 3'd4
    } phase_t;

endpackage

// File: rtl/led_breather_pwm_gen.sv
// Free-running PWM counter with a registered comparator output; idles cleared when inactive.
module pwm_gen
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk_25mhz,
    input  logic                rst_n,
    input  logic                active,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led     <= 1'b0;
        end else if (!active) begin
            pwm_cnt <= '0;
            led     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            led     <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/led_breather.sv
// Triangle-ramp breathing pattern driven by a slow step strobe, with dwell at both extremes.
module led_breather
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS   = DEF_PWM_BITS,
    parameter int unsigned HOLD_STEPS = DEF_HOLD_STEPS
) (
    input  logic                clk_25mhz,
    input  logic                rst_n,
    input  logic                en,
    input  logic                step_tick,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic [2:0]          phase,
    output logic                cycle_done
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    phase_t              state, state_n;
    logic [PWM_BITS-1:0] duty_q, duty_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic                done_q, done_n;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PH_IDLE;
            duty_q   <= '0;
            hold_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            duty_q   <= duty_n;
            hold_cnt <= hold_n;
            done_q   <= done_n;
        end
    end

    // en=0 overrides everything, including a coincident step_tick.
    always_comb begin
        state_n = state;
        duty_n  = duty_q;
        hold_n  = hold_cnt;
        done_n  = 1'b0;
        if (!en) begin
            state_n = PH_IDLE;
            duty_n  = '0;
            hold_n  = '0;
        end else begin
            case (state)
                PH_IDLE: begin
                    state_n = PH_UP;
                    duty_n  = '0;
                    hold_n  = '0;
                end
                PH_UP: if (step_tick) begin
                    if (duty_q == DUTY_MAX) begin
                        state_n = PH_HOLD_HI;
                        hold_n  = '0;
                    end else begin
                        duty_n = duty_q + PWM_BITS'(1);
                    end
                end
                PH_HOLD_HI: if (step_tick) begin
                    hold_n = hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = PH_DOWN;
                    end
                end
                PH_DOWN: if (step_tick) begin
                    if (duty_q == '0) begin
                        state_n = PH_HOLD_LO;
                        hold_n  = '0;
                    end else begin
                        duty_n = duty_q - PWM_BITS'(1);
                    end
                end
                PH_HOLD_LO: if (step_tick) begin
                    hold_n = hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = PH_UP;
                        done_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = PH_IDLE;
                    duty_n  = '0;
                    hold_n  = '0;
                end
            endcase
        end
    end

    always_comb begin
        phase      = state;
        duty       = duty_q;
        cycle_done = done_q;
    end

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .active    (state != PH_IDLE),
        .duty      (duty_q),
        .led       (led)
    );

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather: default instance plus a minimum-hold instance on shared stimulus.
module tb_led_breather;

    logic       clk_25mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       en        = 1'b0;
    logic       step_tick = 1'b0;

    logic       led, led2;
    logic [7:0] duty, duty2;
    logic [2:0] phase, phase2;
    logic       cycle_done, cycle_done2;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned meas   = 0;

    localparam int unsigned S_LED = 0, S_DUTY = 1, S_PHASE = 2, S_DONE = 3;
    localparam int unsigned S2_DUTY = 4, S2_PHASE = 5, S2_DONE = 6, S_MEAS = 7;

    typedef struct {
        string       tag;
        int unsigned sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    always #20 clk_25mhz = ~clk_25mhz;

    led_breather #(
        .PWM_BITS   (8),
        .HOLD_STEPS (16)
    ) dut (
        .clk_25mhz  (clk_25mhz),
        .rst_n      (rst_n),
        .en         (en),
        .step_tick  (step_tick),
        .led        (led),
        .duty       (duty),
        .phase      (phase),
        .cycle_done (cycle_done)
    );

    led_breather #(
        .PWM_BITS   (8),
        .HOLD_STEPS (1)
    ) dut_min (
        .clk_25mhz  (clk_25mhz),
        .rst_n      (rst_n),
        .en         (en),
        .step_tick  (step_tick),
        .led        (led2),
        .duty       (duty2),
        .phase      (phase2),
        .cycle_done (cycle_done2)
    );

    function automatic logic [31:0] sample(input int unsigned s);
        case (s)
            S_LED:    return 32'(led);
            S_DUTY:   return 32'(duty);
            S_PHASE:  return 32'(phase);
            S_DONE:   return 32'(cycle_done);
            S2_DUTY:  return 32'(duty2);
            S2_PHASE: return 32'(phase2);
            S2_DONE:  return 32'(cycle_done2);
            default:  return 32'(meas);
        endcase
    endfunction

    task automatic push(input string tag, input int unsigned sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = sample(e.sig);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Closed-form position within a breath, k ticks after entering UP at duty 0.
    function automatic void breath_exp(input int unsigned k, input int unsigned hold,
                                       output logic [2:0] ph, output logic [7:0] d,
                                       output logic dn);
        int unsigned p;
        p  = k % (512 + 2 * hold);
        dn = (p == 0) && (k > 0);
        if (p <= 255) begin
            ph = 3'd1; d = 8'(p);
        end else if (p < 256 + hold) begin
            ph = 3'd2; d = 8'hFF;
        end else if (p < 512 + hold) begin
            ph = 3'd3; d = 8'(255 - (p - (256 + hold)));
        end else begin
            ph = 3'd4; d = 8'h00;
        end
    endfunction

    task automatic tick_chk(input int unsigned k, input int unsigned gap);
        logic [2:0] ph;
        logic [7:0] d;
        logic       dn;
        @(negedge clk_25mhz);
        step_tick = 1'b1;
        breath_exp(k, 16, ph, d, dn);
        push("breath_phase", S_PHASE, 32'(ph));
        push("breath_duty", S_DUTY, 32'(d));
        push("breath_done", S_DONE, 32'(dn));
        breath_exp(k, 1, ph, d, dn);
        push("min_phase", S2_PHASE, 32'(ph));
        push("min_duty", S2_DUTY, 32'(d));
        push("min_done", S2_DONE, 32'(dn));
        @(posedge clk_25mhz);
        #1;
        drain();
        step_tick = 1'b0;
        @(posedge clk_25mhz);
        #1;
        push("done_one_clk", S_DONE, 32'd0);
        push("min_done_one_clk", S2_DONE, 32'd0);
        drain();
        repeat (gap - 2) @(posedge clk_25mhz);
    endtask

    task automatic count_led(input logic level);
        meas = 0;
        repeat (2) @(posedge clk_25mhz);
        for (int i = 0; i < 256; i++) begin
            @(posedge clk_25mhz);
            #1;
            if (led === level) meas++;
        end
    endtask

    initial begin
        int unsigned cnt_b;
        int unsigned duty_b;
        logic        t;

        repeat (3) @(posedge clk_25mhz);
        #1;
        push("rst_led", S_LED, 32'd0);
        push("rst_duty", S_DUTY, 32'd0);
        push("rst_phase", S_PHASE, 32'd0);
        push("rst_done", S_DONE, 32'd0);
        drain();

        @(negedge clk_25mhz);
        rst_n = 1'b1;
        en    = 1'b1;
        @(posedge clk_25mhz);
        #1;
        push("release_up", S_PHASE, 32'd1);
        drain();

        // Back-to-back ticks with clock-accurate led prediction.
        cnt_b  = 0;
        duty_b = 0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk_25mhz);
            t = (j >= 4) && (j <= 13);
            step_tick = t;
            push("b2b_led", S_LED, 32'(cnt_b < duty_b));
            push("b2b_duty", S_DUTY, 32'(duty_b + 32'(t)));
            @(posedge clk_25mhz);
            #1;
            drain();
            cnt_b  = (cnt_b + 1) % 256;
            duty_b = duty_b + 32'(t);
        end
        step_tick = 1'b0;
        push("b2b_final_duty", S_DUTY, 32'd10);
        drain();

        @(negedge clk_25mhz);
        en = 1'b0;
        @(posedge clk_25mhz);
        #1;
        push("en_off_phase", S_PHASE, 32'd0);
        push("en_off_duty", S_DUTY, 32'd0);
        drain();

        @(negedge clk_25mhz);
        en = 1'b1;
        @(posedge clk_25mhz);
        #1;
        push("pulse_up", S_PHASE, 32'd1);
        drain();
        @(negedge clk_25mhz);
        en = 1'b0;
        @(posedge clk_25mhz);
        #1;
        push("pulse_idle", S_PHASE, 32'd0);
        push("pulse_led", S_LED, 32'd0);
        drain();

        @(negedge clk_25mhz);
        en = 1'b1;
        @(posedge clk_25mhz);
        #1;
        push("breath_start", S_PHASE, 32'd1);
        push("breath_start_duty", S_DUTY, 32'd0);
        drain();

        for (int k = 1; k <= 544; k++) tick_chk(k, 4);

        for (int k = 1; k <= 64; k++) begin
            @(negedge clk_25mhz);
            step_tick = 1'b1;
            @(negedge clk_25mhz);
            step_tick = 1'b0;
        end
        push("duty_40", S_DUTY, 32'h40);
        drain();
        count_led(1'b1);
        push("pwm_hi_40", S_MEAS, 32'd64);
        drain();

        @(posedge clk_25mhz);
        #5;
        rst_n = 1'b0;
        #1;
        push("async_led", S_LED, 32'd0);
        push("async_duty", S_DUTY, 32'd0);
        push("async_phase", S_PHASE, 32'd0);
        push("async_done", S_DONE, 32'd0);
        drain();
        repeat (2) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        rst_n = 1'b1;
        @(posedge clk_25mhz);
        #1;
        push("async_release_up", S_PHASE, 32'd1);
        drain();

        count_led(1'b1);
        push("pwm_hi_00", S_MEAS, 32'd0);
        drain();

        @(negedge clk_25mhz);
        step_tick = 1'b1;
        repeat (255) @(negedge clk_25mhz);
        step_tick = 1'b0;
        push("duty_ff", S_DUTY, 32'hFF);
        push("duty_ff_phase", S_PHASE, 32'd1);
        drain();
        count_led(1'b0);
        push("pwm_lo_ff", S_MEAS, 32'd1);
        drain();

        @(negedge clk_25mhz);
        step_tick = 1'b1;
        @(negedge clk_25mhz);
        step_tick = 1'b0;
        push("enter_hold_hi", S_PHASE, 32'd2);
        drain();

        @(negedge clk_25mhz);
        en        = 1'b0;
        step_tick = 1'b1;
        @(posedge clk_25mhz);
        #1;
        push("simul_phase", S_PHASE, 32'd0);
        push("simul_duty", S_DUTY, 32'd0);
        push("simul_done", S_DONE, 32'd0);
        drain();
        step_tick = 1'b0;

        repeat (2) @(posedge clk_25mhz);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
